// File: rtl/rop3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rop3_pkg
// Description : Shared types and constants for the rop3_stream raster engine:
//               FSM state encoding, named legacy ROP3 codes and the legacy
//               code filter used when ROP3_LEGACY15_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package rop3_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // The fifteen codes supported by the previous-generation LUT block
   localparam logic [7:0] c_rop_blackness   = 8'h00;
   localparam logic [7:0] c_rop_notsrcerase = 8'h11;
   localparam logic [7:0] c_rop_notsrccopy  = 8'h33;
   localparam logic [7:0] c_rop_srcerase    = 8'h44;
   localparam logic [7:0] c_rop_dstinvert   = 8'h55;
   localparam logic [7:0] c_rop_patinvert   = 8'h5A;
   localparam logic [7:0] c_rop_srcinvert   = 8'h66;
   localparam logic [7:0] c_rop_srcand      = 8'h88;
   localparam logic [7:0] c_rop_mergepaint  = 8'hBB;
   localparam logic [7:0] c_rop_mergecopy   = 8'hC0;
   localparam logic [7:0] c_rop_srccopy     = 8'hCC;
   localparam logic [7:0] c_rop_srcpaint    = 8'hEE;
   localparam logic [7:0] c_rop_patcopy     = 8'hF0;
   localparam logic [7:0] c_rop_patpaint    = 8'hFB;
   localparam logic [7:0] c_rop_whiteness   = 8'hFF;

   // True when the code was computed by the previous generation
   function automatic logic rop3_legal(input logic [7:0] code);
      logic w_ok;
      case (code)
         c_rop_blackness, c_rop_notsrcerase, c_rop_notsrccopy,
         c_rop_srcerase,  c_rop_dstinvert,   c_rop_patinvert,
         c_rop_srcinvert, c_rop_srcand,      c_rop_mergepaint,
         c_rop_mergecopy, c_rop_srccopy,     c_rop_srcpaint,
         c_rop_patcopy,   c_rop_patpaint,    c_rop_whiteness: w_ok = 1'b1;
         default:                                            w_ok = 1'b0;
      endcase
      return w_ok;
   endfunction

endpackage : rop3_pkg
`default_nettype wire

// File: rtl/rop3_bitlut.sv
`default_nettype none
// ============================================================================
// Module      : rop3_bitlut
// Description : Combinational ROP3 evaluator. Each result bit selects one bit
//               of the 8-bit ROP code using {P,S,D} of that bit position as
//               index, P being the most significant index bit.
// Revision    : 1.0 - initial release
// ============================================================================
module rop3_bitlut #(
   parameter int N = 8
) (
   input  logic [7:0]   i_mode,
   input  logic [N-1:0] i_p,
   input  logic [N-1:0] i_s,
   input  logic [N-1:0] i_d,
   output logic [N-1:0] o_result
);

   for (genvar i = 0; i < N; i++) begin : g_bit
      logic [2:0] w_idx;
      assign w_idx       = {i_p[i], i_s[i], i_d[i]};
      assign o_result[i] = i_mode[w_idx];
   end

endmodule : rop3_bitlut
`default_nettype wire

// File: rtl/rop3_stream.sv
`default_nettype none
// ============================================================================
// Module      : rop3_stream
// Description : Streaming ROP3 engine. A command latches the ROP code and a
//               burst length; P/S/D beats then flow through a two-stage
//               pipeline (stage1 = operand register, stage2 = result
//               register) with valid/ready handshakes on both sides.
//               Optional macro ROP3_LEGACY15_EN restricts computation to the
//               fifteen previous-generation codes (others produce zero).
// Revision    : 1.0 - initial release
// ============================================================================
module rop3_stream
   import rop3_pkg::*;
#(
   parameter int N     = 8,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic [7:0]       cmd_mode,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     P,
   input  logic [N-1:0]     S,
   input  logic [N-1:0]     D,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     Result,
   output logic             out_last,
   output logic             done
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_done_nxt;
   logic [7:0]         r_mode;
   logic [LEN_W-1:0]   r_remaining;
   logic               r_done;

   logic               r_s1_valid;
   logic [N-1:0]       r_s1_p;
   logic [N-1:0]       r_s1_s;
   logic [N-1:0]       r_s1_d;
   logic               r_s1_last;

   logic               r_s2_valid;
   logic [N-1:0]       r_result;
   logic               r_out_last;

   logic               w_s2_adv;
   logic               w_s1_free;
   logic               w_in_ready;
   logic               w_in_hs;
   logic               w_out_hs;
   logic               w_cmd_acc;
   logic               w_last_in;
   logic [7:0]         w_mode_eff;
   logic [N-1:0]       w_lut;

   // Stage2 can take a new value when empty or when its beat leaves now;
   // stage1 is free under the same condition or when it is empty.
   assign w_s2_adv   = !r_s2_valid || out_ready;
   assign w_s1_free  = !r_s1_valid || w_s2_adv;
   assign w_in_ready = (r_state == ST_RUN) && (r_remaining != '0) && w_s1_free;
   assign w_in_hs    = in_valid && w_in_ready;
   assign w_out_hs   = r_s2_valid && out_ready;
   assign w_cmd_acc  = (r_state == ST_IDLE) && cmd_valid;
   assign w_last_in  = w_in_hs && (r_remaining == LEN_W'(1));

`ifdef ROP3_LEGACY15_EN
   assign w_mode_eff = rop3_legal(r_mode) ? r_mode : c_rop_blackness;
`else
   assign w_mode_eff = r_mode;
`endif

   rop3_bitlut #(
      .N        (N)
   ) u_bitlut (
      .i_mode   (w_mode_eff),
      .i_p      (r_s1_p),
      .i_s      (r_s1_s),
      .i_d      (r_s1_d),
      .o_result (w_lut)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and completion decode; done is registered so it appears the
   // cycle after the final output handshake (or after a zero-length command)
   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd_len != '0) w_state_nxt = ST_RUN;
               else               w_done_nxt  = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_last_in) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_out_hs && r_out_last) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Command latch, beat countdown and done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode      <= '0;
         r_remaining <= '0;
         r_done      <= 1'b0;
      end else begin
         if (w_cmd_acc) begin
            r_mode      <= cmd_mode;
            r_remaining <= cmd_len;
         end else if (w_in_hs) begin
            r_remaining <= r_remaining - LEN_W'(1);
         end
         r_done <= w_done_nxt;
      end
   end

   // Stage1: capture operands on input handshake, tag the final beat
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_p     <= '0;
         r_s1_s     <= '0;
         r_s1_d     <= '0;
         r_s1_last  <= 1'b0;
      end else if (w_s1_free) begin
         r_s1_valid <= w_in_hs;
         if (w_in_hs) begin
            r_s1_p    <= P;
            r_s1_s    <= S;
            r_s1_d    <= D;
            r_s1_last <= w_last_in;
         end
      end
   end

   // Stage2: register the ROP result; hold under backpressure and keep the
   // last data while empty
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_result   <= '0;
         r_out_last <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_result   <= w_lut;
            r_out_last <= r_s1_last;
         end
      end
   end

   assign busy      = (r_state != ST_IDLE);
   assign in_ready  = w_in_ready;
   assign out_valid = r_s2_valid;
   assign Result    = r_result;
   assign out_last  = r_out_last;
   assign done      = r_done;

endmodule : rop3_stream
`default_nettype wire

// File: tb/tb_rop3_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rop3_stream
// Description : Self-checking bench for rop3_stream. Expected results are
//               queued when a beat is accepted and compared when the engine
//               delivers it. Honours ROP3_LEGACY15_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rop3_stream;

   localparam int N     = 8;
   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic [7:0]       cmd_mode = '0;
   logic [LEN_W-1:0] cmd_len = '0;
   logic             busy;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [N-1:0]     P = '0;
   logic [N-1:0]     S = '0;
   logic [N-1:0]     D = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [N-1:0]     Result;
   logic             out_last;
   logic             done;

   rop3_stream #(.N(N), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_mode  (cmd_mode),
      .cmd_len   (cmd_len),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .P         (P),
      .S         (S),
      .D         (D),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Result    (Result),
      .out_last  (out_last),
      .done      (done)
   );

   always #5 clk = ~clk;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [N:0]  sb_q[$];
   int          exp_done_cyc = -1;
   int          done_seen = 0;
   int          first_hs_cyc = -1;
   int          first_out_cyc = -1;
   int          last_out_cyc = -1;
   int          n_out = 0;
   logic        lat_pending = 1'b0;
   logic        track_stall = 1'b0;
   logic        saw_stall = 1'b0;
   int          bp_mode = 0;
   int          bp_idx = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

`ifdef ROP3_LEGACY15_EN
   function automatic logic legacy_ok(input logic [7:0] m);
      return m inside {8'h00, 8'h11, 8'h33, 8'h44, 8'h55, 8'h5A, 8'h66, 8'h88,
                       8'hBB, 8'hC0, 8'hCC, 8'hEE, 8'hF0, 8'hFB, 8'hFF};
   endfunction
`endif

   // Sum-of-minterms reference: each set code bit contributes the pixels
   // whose (P,S,D) triple equals that bit's index
   function automatic logic [N-1:0] model(input logic [7:0] m, input logic [N-1:0] p,
                                          input logic [N-1:0] s, input logic [N-1:0] d);
      logic [N-1:0] r;
      logic [2:0]   k3;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         k3 = k[2:0];
         if (m[k]) r = r | ((k3[2] ? p : ~p) & (k3[1] ? s : ~s) & (k3[0] ? d : ~d));
      end
`ifdef ROP3_LEGACY15_EN
      if (!legacy_ok(m)) r = '0;
`endif
      return r;
   endfunction

   // Cycle counter
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Output-ready pattern generator
   initial forever begin
      @(posedge clk);
      #1;
      if (bp_mode == 1) begin
         out_ready = (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
         bp_idx++;
      end else if (bp_mode == 2) begin
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Output monitor / scoreboard checker
   initial forever begin
      logic [N:0] e;
      @(negedge clk);
      if (!rst) begin
         if (done) begin
            chk("done_cycle", 32'(cyc), 32'(exp_done_cyc));
            done_seen++;
            exp_done_cyc = -1;
         end
         if (track_stall && busy && in_valid && !in_ready) saw_stall = 1'b1;
         if (out_valid && lat_pending) begin
            chk("latency", 32'(cyc - first_hs_cyc), 32'd2);
            lat_pending = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("sb_unexpected_beat", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("result", 32'(Result), 32'(e[N-1:0]));
               chk("out_last", 32'(out_last), 32'(e[N]));
               if (first_out_cyc < 0) first_out_cyc = cyc;
               last_out_cyc = cyc;
               n_out++;
               if (e[N]) exp_done_cyc = cyc + 1;
            end
         end
      end
   end

   // Issue a command; called at posedge+1 while the engine is idle
   task automatic send_cmd(input logic [7:0] m, input logic [LEN_W-1:0] l);
      cmd_valid = 1'b1;
      cmd_mode  = m;
      cmd_len   = l;
      @(negedge clk);
      if (l == '0) exp_done_cyc = cyc + 1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // Present one beat until accepted and queue its expected result
   task automatic send_beat(input logic [N-1:0] p, input logic [N-1:0] s, input logic [N-1:0] d,
                            input logic [N-1:0] exp_res, input logic lst);
      int t;
      logic acc;
      in_valid = 1'b1;
      P = p;
      S = s;
      D = d;
      t = 0;
      acc = 1'b0;
      while (!acc && t < 200) begin
         @(negedge clk);
         if (in_ready) acc = 1'b1;
         else          t++;
      end
      if (!acc) chk("in_ready_timeout", 32'd0, 32'd1);
      else begin
         if (first_hs_cyc < 0) first_hs_cyc = cyc;
         sb_q.push_back({lst, exp_res});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int prev);
      int t;
      t = 0;
      while (done_seen == prev && t < 300) begin
         @(posedge clk);
         t++;
      end
      if (done_seen == prev) chk("done_timeout", 32'd0, 32'd1);
      #1;
   endtask

   initial begin
      int prev;
      logic [7:0]   m;
      logic [N-1:0] rp, rs, rd;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", 32'(Result), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Decode: 0x5A = P xor D
      prev = done_seen;
      send_cmd(8'h5A, 16'd1);
      send_beat(8'hF0, 8'h00, 8'hCC, 8'h3C, 1'b1);
      wait_done(prev);

      // Non-legacy code 0x96 = P xor S xor D
      prev = done_seen;
      send_cmd(8'h96, 16'd1);
`ifdef ROP3_LEGACY15_EN
      send_beat(8'hAA, 8'hCC, 8'hF0, 8'h00, 1'b1);
`else
      send_beat(8'hAA, 8'hCC, 8'hF0, 8'h96, 1'b1);
`endif
      wait_done(prev);

      // Throughput and ordering, out_ready held high
      prev = done_seen;
      first_hs_cyc = -1;
      first_out_cyc = -1;
      n_out = 0;
      lat_pending = 1'b1;
      send_cmd(8'hCC, 16'd8);
      for (int i = 0; i < 8; i++)
         send_beat(8'(i * 37), 8'(i), 8'(~i), 8'(i), i == 7);
      wait_done(prev);
      chk("tput_span", 32'(last_out_cyc - first_out_cyc), 32'd7);
      chk("tput_count", 32'(n_out), 32'd8);

      // Backpressure: out_ready 1,0,0,1,...
      prev = done_seen;
      n_out = 0;
      saw_stall = 1'b0;
      track_stall = 1'b1;
      bp_idx = 0;
      bp_mode = 1;
      send_cmd(8'hCC, 16'd8);
      for (int i = 0; i < 8; i++)
         send_beat(8'(i * 37), 8'(i), 8'(~i), 8'(i), i == 7);
      wait_done(prev);
      bp_mode = 0;
      track_stall = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      chk("bp_stall_seen", 32'(saw_stall), 32'd1);
      chk("bp_count", 32'(n_out), 32'd8);

      // Zero length
      prev = done_seen;
      send_cmd(8'h33, 16'd0);
      @(negedge clk);
      chk("zl_busy", 32'(busy), 32'd0);
      chk("zl_in_ready", 32'(in_ready), 32'd0);
      wait_done(prev);
      chk("zl_busy_after", 32'(busy), 32'd0);

      // Random codes and data under random backpressure
      for (int b = 0; b < 3; b++) begin
         prev = done_seen;
         m = 8'($urandom);
         bp_mode = 2;
         send_cmd(m, 16'd6);
         for (int i = 0; i < 6; i++) begin
            rp = 8'($urandom);
            rs = 8'($urandom);
            rd = 8'($urandom);
            send_beat(rp, rs, rd, model(m, rp, rs, rd), i == 5);
         end
         wait_done(prev);
         bp_mode = 0;
         @(posedge clk);
         #1;
         out_ready = 1'b1;
      end

      // Reset mid-burst after the third handshake
      prev = done_seen;
      send_cmd(8'hF0, 16'd8);
      for (int i = 0; i < 3; i++)
         send_beat(8'(i + 1), 8'h55, 8'hAA, 8'(i + 1), 1'b0);
      rst = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      sb_q.delete();
      exp_done_cyc = -1;
      @(negedge clk);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_in_ready", 32'(in_ready), 32'd0);
      chk("mrst_out_valid", 32'(out_valid), 32'd0);
      chk("mrst_result", 32'(Result), 32'd0);
      chk("mrst_out_last", 32'(out_last), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("mrst_no_done", 32'(done_seen), 32'(prev));
      send_cmd(8'hF0, 16'd2);
      send_beat(8'h5A, 8'h00, 8'hFF, 8'h5A, 1'b0);
      send_beat(8'hA5, 8'hFF, 8'h00, 8'hA5, 1'b1);
      wait_done(prev);

      repeat (3) @(posedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_rop3_stream
`default_nettype wire
